hazard_controller: RTL and testbench

//  Pipeline stall/flush controller for the 5-stage RV32I core; sits beside the forwarding unit and drives the

---
 rtl/hazard_controller_pkg.sv | 11 +
 rtl/hazard_controller_mem_resp_buffer.sv | 32 +++
 rtl/hazard_controller.sv | 134 +++++++++++++
 tb/tb_hazard_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_controller_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hc_state_e;

    localparam int CNT_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/hazard_controller_mem_resp_buffer.sv
// One-entry sticky holder for a memory response that arrives while the pipe is frozen.
module mem_resp_buffer
    import hazard_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        resp,
    input  logic [31:0] rdata,
    output logic        done,
    output logic [31:0] data_out
);

    logic [31:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            done   <= 1'b0;
            data_q <= '0;
        end else if (advance) begin
            done   <= 1'b0;
            data_q <= '0;
        end else if (resp) begin
            done   <= 1'b1;
            data_q <= rdata;
        end
    end

    // Once captured, the held copy stands in for the live bus until the pipe moves.
    assign data_out = done ? data_q : rdata;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush controller for the 5-stage RV32I pipeline with miss freeze and perf counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           IF_ID_rs1_i,
    input  logic [4:0]           IF_ID_rs2_i,
    input  logic                 IF_ID_uses_rs2_i,
    input  logic [4:0]           ID_EX_rd_i,
    input  logic                 ID_EX_mem_read_i,
    input  logic                 branch_taken_i,
    input  logic                 EX_MEM_mem_read_i,
    input  logic                 EX_MEM_mem_write_i,
    input  logic                 imem_resp_i,
    input  logic [31:0]          imem_rdata_i,
    input  logic                 dmem_resp_i,
    input  logic [31:0]          dmem_rdata_i,
    output logic [31:0]          instr_o,
    output logic [31:0]          dmem_rdata_o,
    output logic                 dmem_read_o,
    output logic                 dmem_write_o,
    output logic                 load_pc_o,
    output logic                 load_if_id_o,
    output logic                 load_id_ex_o,
    output logic                 load_ex_mem_o,
    output logic                 load_mem_wb_o,
    output logic                 flush_if_id_o,
    output logic                 flush_id_ex_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    hc_state_e   state_q, state_d;
    logic        i_done, d_done;
    logic        dmem_active, i_ok, d_ok, advance;
    logic        load_use, bubble;

    assign dmem_active = EX_MEM_mem_read_i | EX_MEM_mem_write_i;
    assign i_ok        = imem_resp_i | i_done;
    assign d_ok        = ~dmem_active | dmem_resp_i | d_done;
    assign advance     = i_ok & d_ok;

    // A load in EX cannot forward to ID in time; x0 never creates a dependency.
    assign load_use = ID_EX_mem_read_i & (|ID_EX_rd_i) &
                      ((ID_EX_rd_i == IF_ID_rs1_i) |
                       (IF_ID_uses_rs2_i & (ID_EX_rd_i == IF_ID_rs2_i)));
    assign bubble   = advance & ~branch_taken_i & load_use;

    mem_resp_buffer u_imem_buf (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .resp     (imem_resp_i),
        .rdata    (imem_rdata_i),
        .done     (i_done),
        .data_out (instr_o)
    );

    mem_resp_buffer u_dmem_buf (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .resp     (dmem_resp_i),
        .rdata    (dmem_rdata_i),
        .done     (d_done),
        .data_out (dmem_rdata_o)
    );

    assign dmem_read_o  = ~rst & EX_MEM_mem_read_i  & ~d_done;
    assign dmem_write_o = ~rst & EX_MEM_mem_write_i & ~d_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (!advance) state_d = WAIT;
            WAIT:    if (advance)  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        load_pc_o     = 1'b0;
        load_if_id_o  = 1'b0;
        load_id_ex_o  = 1'b0;
        load_ex_mem_o = 1'b0;
        load_mem_wb_o = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        if (!rst && advance) begin
            load_pc_o     = 1'b1;
            load_if_id_o  = 1'b1;
            load_id_ex_o  = 1'b1;
            load_ex_mem_o = 1'b1;
            load_mem_wb_o = 1'b1;
            if (branch_taken_i) begin
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID, inject a bubble into EX; older stages drain.
                load_pc_o     = 1'b0;
                load_if_id_o  = 1'b0;
                flush_id_ex_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (!advance || bubble) stall_cnt_o <= sat_inc(stall_cnt_o);
            if (advance && branch_taken_i) flush_cnt_o <= sat_inc(flush_cnt_o);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and randomized checks of hazard_controller against a cycle-level reference model.
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    IF_ID_rs1_i, IF_ID_rs2_i, ID_EX_rd_i;
    logic          IF_ID_uses_rs2_i, ID_EX_mem_read_i, branch_taken_i;
    logic          EX_MEM_mem_read_i, EX_MEM_mem_write_i;
    logic          imem_resp_i, dmem_resp_i;
    logic [31:0]   imem_rdata_i, dmem_rdata_i;
    logic [31:0]   instr_o, dmem_rdata_o;
    logic          dmem_read_o, dmem_write_o;
    logic          load_pc_o, load_if_id_o, load_id_ex_o, load_ex_mem_o, load_mem_wb_o;
    logic          flush_if_id_o, flush_id_ex_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    int tests = 0;
    int fails = 0;

    // Reference model state: what has been captured, what has been counted.
    bit          m_ivalid, m_dvalid, m_waiting;
    logic [31:0] m_idata, m_ddata;
    int          m_stall, m_flush;

    hazard_controller #(.CNT_WIDTH(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .IF_ID_rs1_i        (IF_ID_rs1_i),
        .IF_ID_rs2_i        (IF_ID_rs2_i),
        .IF_ID_uses_rs2_i   (IF_ID_uses_rs2_i),
        .ID_EX_rd_i         (ID_EX_rd_i),
        .ID_EX_mem_read_i   (ID_EX_mem_read_i),
        .branch_taken_i     (branch_taken_i),
        .EX_MEM_mem_read_i  (EX_MEM_mem_read_i),
        .EX_MEM_mem_write_i (EX_MEM_mem_write_i),
        .imem_resp_i        (imem_resp_i),
        .imem_rdata_i       (imem_rdata_i),
        .dmem_resp_i        (dmem_resp_i),
        .dmem_rdata_i       (dmem_rdata_i),
        .instr_o            (instr_o),
        .dmem_rdata_o       (dmem_rdata_o),
        .dmem_read_o        (dmem_read_o),
        .dmem_write_o       (dmem_write_o),
        .load_pc_o          (load_pc_o),
        .load_if_id_o       (load_if_id_o),
        .load_id_ex_o       (load_id_ex_o),
        .load_ex_mem_o      (load_ex_mem_o),
        .load_mem_wb_o      (load_mem_wb_o),
        .flush_if_id_o      (flush_if_id_o),
        .flush_id_ex_o      (flush_id_ex_o),
        .stall_cnt_o        (stall_cnt_o),
        .flush_cnt_o        (flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        IF_ID_rs1_i = 5'd1; IF_ID_rs2_i = 5'd2; IF_ID_uses_rs2_i = 1'b0;
        ID_EX_rd_i = 5'd3; ID_EX_mem_read_i = 1'b0; branch_taken_i = 1'b0;
        EX_MEM_mem_read_i = 1'b0; EX_MEM_mem_write_i = 1'b0;
        imem_resp_i = 1'b1; dmem_resp_i = 1'b0;
        imem_rdata_i = 32'h0000_0013; dmem_rdata_i = 32'h0;
    endtask

    // Checks every output for the current cycle, then advances one clock and updates the model.
    task automatic step(input string tag);
        bit adv, dep, frozen;
        logic [4:0] exp_loads, got_loads;
        logic [1:0] exp_flush, got_flush;
        #1;
        dep = ID_EX_mem_read_i && ID_EX_rd_i != 0 &&
              (ID_EX_rd_i == IF_ID_rs1_i || (IF_ID_uses_rs2_i && ID_EX_rd_i == IF_ID_rs2_i));
        adv = (imem_resp_i || m_ivalid) &&
              (!(EX_MEM_mem_read_i || EX_MEM_mem_write_i) || dmem_resp_i || m_dvalid);
        frozen = rst || !adv;
        if (frozen)              begin exp_loads = 5'b00000; exp_flush = 2'b00; end
        else if (branch_taken_i) begin exp_loads = 5'b11111; exp_flush = 2'b11; end
        else if (dep)            begin exp_loads = 5'b00111; exp_flush = 2'b01; end
        else                     begin exp_loads = 5'b11111; exp_flush = 2'b00; end
        got_loads = {load_pc_o, load_if_id_o, load_id_ex_o, load_ex_mem_o, load_mem_wb_o};
        got_flush = {flush_if_id_o, flush_id_ex_o};
        chk({tag, ".loads"}, 32'(got_loads), 32'(exp_loads));
        chk({tag, ".flush"}, 32'(got_flush), 32'(exp_flush));
        chk({tag, ".dread"}, 32'(dmem_read_o), 32'(!rst && EX_MEM_mem_read_i && !m_dvalid));
        chk({tag, ".dwrite"}, 32'(dmem_write_o), 32'(!rst && EX_MEM_mem_write_i && !m_dvalid));
        chk({tag, ".instr"}, instr_o, m_ivalid ? m_idata : imem_rdata_i);
        chk({tag, ".drdata"}, dmem_rdata_o, m_dvalid ? m_ddata : dmem_rdata_i);
        chk({tag, ".stall"}, 32'(stall_cnt_o), 32'(m_stall));
        chk({tag, ".fcnt"}, 32'(flush_cnt_o), 32'(m_flush));
        chk({tag, ".state"}, 32'(dut.state_q), m_waiting ? 32'(WAIT) : 32'(RUN));
        @(posedge clk);
        if (rst) begin
            m_ivalid = 0; m_dvalid = 0; m_waiting = 0;
            m_idata = 0; m_ddata = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (adv) begin
                m_ivalid = 0; m_dvalid = 0; m_idata = 0; m_ddata = 0;
            end else begin
                if (imem_resp_i) begin m_ivalid = 1; m_idata = imem_rdata_i; end
                if (dmem_resp_i) begin m_dvalid = 1; m_ddata = dmem_rdata_i; end
            end
            if ((!adv || (dep && !branch_taken_i)) && m_stall < MAX) m_stall++;
            if (adv && branch_taken_i && m_flush < MAX) m_flush++;
            m_waiting = !adv;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_ivalid = 0; m_dvalid = 0; m_waiting = 0;
        m_idata = 0; m_ddata = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        step("reset0");
        step("reset1");
        rst = 1'b0;
        chk("rst_stall_zero", 32'(stall_cnt_o), 32'd0);

        // Load-use on rs1: one bubble, then normal flow.
        idle_inputs();
        dmem_resp_i = 1'b1;
        ID_EX_mem_read_i = 1'b1; ID_EX_rd_i = 5'd5; IF_ID_rs1_i = 5'd5;
        #1;
        chk("lu_pc", 32'(load_pc_o), 32'd0);
        chk("lu_ifid", 32'(load_if_id_o), 32'd0);
        chk("lu_flush", 32'(flush_id_ex_o), 32'd1);
        step("lu");
        ID_EX_mem_read_i = 1'b0;
        #1;
        chk("lu_after_pc", 32'(load_pc_o), 32'd1);
        chk("lu_after_stall", 32'(stall_cnt_o), 32'd1);
        step("lu_after");

        // Load to x0 never stalls.
        ID_EX_mem_read_i = 1'b1; ID_EX_rd_i = 5'd0; IF_ID_rs1_i = 5'd0;
        #1;
        chk("x0_pc", 32'(load_pc_o), 32'd1);
        step("x0");
        chk("x0_stall", 32'(stall_cnt_o), 32'd1);

        // Branch wins over load-use.
        ID_EX_rd_i = 5'd7; IF_ID_rs2_i = 5'd7; IF_ID_uses_rs2_i = 1'b1; branch_taken_i = 1'b1;
        #1;
        chk("br_pc", 32'(load_pc_o), 32'd1);
        chk("br_flush", 32'({flush_if_id_o, flush_id_ex_o}), 32'd3);
        step("br");
        chk("br_fcnt", 32'(flush_cnt_o), 32'd1);

        // Split miss: I at cycle 2, D at cycle 5.
        do_reset();
        EX_MEM_mem_read_i = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            imem_resp_i  = (c == 2);
            imem_rdata_i = (c == 2) ? 32'hA5A5_0001 : 32'hBAD0_0000 + 32'(c);
            dmem_resp_i  = (c == 5);
            dmem_rdata_i = (c == 5) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            if (c < 5) chk("miss_freeze", 32'(load_pc_o), 32'd0);
            if (c == 5) begin
                chk("miss_instr", instr_o, 32'hA5A5_0001);
                chk("miss_drdata", dmem_rdata_o, 32'hDEAD_BEEF);
                chk("miss_adv", 32'(load_mem_wb_o), 32'd1);
            end
            step("miss");
        end
        chk("miss_stall", 32'(stall_cnt_o), 32'd5);

        // D first at cycle 1, I at cycle 4.
        do_reset();
        EX_MEM_mem_read_i = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            imem_resp_i  = (c == 4);
            dmem_resp_i  = (c == 1);
            dmem_rdata_i = (c == 1) ? 32'h1234_5678 : 32'h5555_0000 + 32'(c);
            #1;
            if (c >= 2) chk("dfirst_dread", 32'(dmem_read_o), 32'd0);
            if (c == 4) chk("dfirst_drdata", dmem_rdata_o, 32'h1234_5678);
            step("dfirst");
        end

        // Reset in the middle of a D-miss with data already buffered.
        do_reset();
        EX_MEM_mem_read_i = 1'b1; imem_resp_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            dmem_resp_i = (c == 1);
            dmem_rdata_i = 32'hCAFE_0000 + 32'(c);
            step("midrst");
        end
        dmem_resp_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_outs", 32'({load_pc_o, load_if_id_o, load_id_ex_o, load_ex_mem_o,
                                load_mem_wb_o, flush_if_id_o, flush_id_ex_o, dmem_read_o,
                                dmem_write_o}), 32'd0);
        step("midrst_rst");
        rst = 1'b0;
        #1;
        chk("midrst_state", 32'(dut.state_q), 32'(RUN));
        chk("midrst_done", 32'({dut.u_imem_buf.done, dut.u_dmem_buf.done}), 32'd0);
        chk("midrst_cnt", 32'({stall_cnt_o, flush_cnt_o}), 32'd0);
        chk("midrst_dread", 32'(dmem_read_o), 32'd1);
        step("midrst_post");

        // Randomized traffic; small register range keeps hazards frequent and counters saturate.
        for (int n = 0; n < 600; n++) begin
            rst                = ($urandom_range(0, 79) == 0);
            IF_ID_rs1_i        = 5'($urandom_range(0, 3));
            IF_ID_rs2_i        = 5'($urandom_range(0, 3));
            IF_ID_uses_rs2_i   = 1'($urandom_range(0, 1));
            ID_EX_rd_i         = 5'($urandom_range(0, 3));
            ID_EX_mem_read_i   = 1'($urandom_range(0, 1));
            branch_taken_i     = ($urandom_range(0, 4) == 0);
            EX_MEM_mem_read_i  = ($urandom_range(0, 2) == 0);
            EX_MEM_mem_write_i = !EX_MEM_mem_read_i && ($urandom_range(0, 3) == 0);
            imem_resp_i        = ($urandom_range(0, 9) < 6);
            dmem_resp_i        = ($urandom_range(0, 9) < 5);
            imem_rdata_i       = $urandom;
            dmem_rdata_i       = $urandom;
            step("rand");
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
